// File: rtl/muxn_pkg.sv
// muxn_arb shared types and defaults.
// Used by the N-input registered mux and its round-robin arbiter.
package muxn_pkg;

  typedef enum logic {
    MODE_SEL,
    MODE_RR
  } mux_mode_e;

  localparam int DEFAULT_WIDTH = 64;
  localparam int DEFAULT_N     = 4;

endpackage

// File: rtl/muxn_arb_rr_arbiter.sv
// Rotating-priority pick for muxn_arb.
// Scans ptr+1 .. ptr cyclically and returns the first requester.
module rr_arbiter
  import muxn_pkg::*;
#(
  parameter int N    = DEFAULT_N,
  parameter int SELW = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [SELW-1:0] ptr,
  output logic [SELW-1:0] gnt_idx,
  output logic            gnt_any
);

  logic [SELW-1:0] c;

  // Walk farthest-to-nearest so the nearest hit is the last write
  always_comb begin
    gnt_idx = '0;
    gnt_any = 1'b0;
    c       = '0;
    for (int i = N; i >= 1; i--) begin
      c = SELW'((int'(ptr) + i) % N);
      if (req[c]) begin
        gnt_idx = c;
        gnt_any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/muxn_arb.sv
// N-input registered mux with valid/ready on every channel.
// MUXN_ARB_RR_EN builds the round-robin mode, ptr and arbiter.
module muxn_arb
  import muxn_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int N     = DEFAULT_N,
  parameter int SELW  = $clog2(N)
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [N-1:0][WIDTH-1:0]   in_data,
  input  logic [N-1:0]              in_valid,
  output logic [N-1:0]              in_ready,
  input  logic [SELW-1:0]           sel,
  input  logic                      sel_mode,
  output logic [WIDTH-1:0]          out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [SELW-1:0]           out_src
);

  logic            load;
  logic            xfer;
  logic            gok;
  logic [SELW-1:0] gidx;

  assign load = !out_valid || out_ready;

`ifdef MUXN_ARB_RR_EN
  logic [SELW-1:0] ptr;
  logic [SELW-1:0] rr_idx;
  logic            rr_any;
  mux_mode_e       mode;

  assign mode = mux_mode_e'(sel_mode);

  rr_arbiter #(
    .N    (N),
    .SELW (SELW)
  ) u_rr (
    .req     (in_valid),
    .ptr     (ptr),
    .gnt_idx (rr_idx),
    .gnt_any (rr_any)
  );

  // Current mode picks the grant source
  always_comb begin
    gidx = sel;
    gok  = (int'(sel) < N);
    if (mode == MODE_RR) begin
      gidx = rr_idx;
      gok  = rr_any;
    end
  end

  // Priority rotates past the channel that just transferred
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ptr <= SELW'(N - 1);
    end else if (mode == MODE_RR && xfer) begin
      ptr <= gidx;
    end
  end
`else
  logic unused_mode;

  assign unused_mode = sel_mode;
  assign gidx        = sel;
  assign gok         = (int'(sel) < N);
`endif

  // One-hot ready on the granted channel when the register can load
  always_comb begin
    in_ready = '0;
    if (load && gok) begin
      in_ready[gidx] = 1'b1;
    end
  end

  assign xfer = |(in_ready & in_valid);

  // One-entry output register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= '0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= in_data[gidx];
      out_src   <= gidx;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_muxn_arb.sv
// Self-checking bench for muxn_arb (N=4 main, N=3 boundary).
// Scoreboard monitor plus per-scenario tasks.
module tb_muxn_arb;

  logic              clk;
  logic              reset_n;
  logic [3:0][63:0]  in_data;
  logic [3:0]        in_valid;
  logic [3:0]        in_ready;
  logic [1:0]        sel;
  logic              sel_mode;
  logic [63:0]       out_data;
  logic              out_valid;
  logic              out_ready;
  logic [1:0]        out_src;

  logic [2:0][7:0]   in_data3;
  logic [2:0]        in_valid3;
  logic [2:0]        in_ready3;
  logic [1:0]        sel3;
  logic [7:0]        out_data3;
  logic              out_valid3;
  logic              out_ready3;
  logic [1:0]        out_src3;

  int checks = 0;
  int errors = 0;
  bit started = 0;

  typedef struct packed {
    logic [63:0] d;
    logic [1:0]  s;
  } exp_t;

  exp_t q[$];
  logic [1:0] mptr = 2'd3;

  muxn_arb #(.WIDTH(64), .N(4)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sel       (sel),
    .sel_mode  (sel_mode),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_src   (out_src)
  );

  muxn_arb #(.WIDTH(8), .N(3)) dut3 (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_data   (in_data3),
    .in_valid  (in_valid3),
    .in_ready  (in_ready3),
    .sel       (sel3),
    .sel_mode  (1'b0),
    .out_data  (out_data3),
    .out_valid (out_valid3),
    .out_ready (out_ready3),
    .out_src   (out_src3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: model grant, push on input transfer, pop on output
  always @(negedge clk) begin : mon
    logic [3:0] em;
    logic [1:0] g;
    logic       gok;
    logic       lm;
    int         c;
    exp_t       e;
    if (started) begin
      lm  = (q.size() == 0) || out_ready;
      em  = '0;
      g   = sel;
      gok = 1'b1;
      c   = 0;
`ifdef MUXN_ARB_RR_EN
      if (sel_mode) begin
        gok = 1'b0;
        for (int k = 4; k >= 1; k--) begin
          c = (int'(mptr) + k) % 4;
          if (in_valid[c]) begin
            g   = 2'(c);
            gok = 1'b1;
          end
        end
      end
`endif
      if (lm && gok) em[g] = 1'b1;
      checks++;
      if (out_valid !== (q.size() != 0)) begin
        errors++;
        $display("FAIL sb_valid got %b want %b",
                 out_valid, q.size() != 0);
      end
      if (out_valid === 1'b1 && out_ready === 1'b1
          && q.size() > 0) begin
        e = q.pop_front();
        checks++;
        if ({out_data, out_src} !== e) begin
          errors++;
          $display("FAIL sb_word got %h/%0d want %h/%0d",
                   out_data, out_src, e.d, e.s);
        end
      end
      checks++;
      if (in_ready !== em) begin
        errors++;
        $display("FAIL sb_ready got %b want %b", in_ready, em);
      end
      if (!reset_n) begin
        q.delete();
        mptr = 2'd3;
      end else if ((in_valid & em) != 4'b0) begin
        q.push_back({in_data[g], g});
`ifdef MUXN_ARB_RR_EN
        if (sel_mode) mptr = g;
`endif
      end
    end
  end

  task automatic test_reset;
    reset_n    = 1'b0;
    in_data    = '0;
    in_valid   = '0;
    sel        = '0;
    sel_mode   = 1'b0;
    out_ready  = 1'b0;
    in_data3   = '0;
    in_valid3  = '0;
    sel3       = '0;
    out_ready3 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_valid got %b want 0", out_valid);
    end
    checks++;
    if (out_data !== 64'h0) begin
      errors++;
      $display("FAIL rst_data got %h want 0", out_data);
    end
    checks++;
    if (out_src !== 2'd0) begin
      errors++;
      $display("FAIL rst_src got %0d want 0", out_src);
    end
    checks++;
    if (out_valid3 !== 1'b0) begin
      errors++;
      $display("FAIL rst_valid3 got %b want 0", out_valid3);
    end
    reset_n = 1'b1;
    started = 1'b1;
  endtask

  task automatic test_passthrough;
    @(posedge clk);
    #1;
    sel         = 2'd2;
    in_valid    = 4'b0100;
    in_data[2]  = 64'hDEAD_BEEF;
    out_ready   = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if (in_ready !== 4'b0100) begin
      errors++;
      $display("FAIL pt_ready0 got %b want 0100", in_ready);
    end
    @(posedge clk);
    #2;
    checks++;
    if (out_data !== 64'hDEAD_BEEF || out_src !== 2'd2
        || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL pt_out got %h/%0d/%b want deadbeef/2/1",
               out_data, out_src, out_valid);
    end
    checks++;
    if (in_ready !== 4'b0100) begin
      errors++;
      $display("FAIL pt_ready1 got %b want 0100", in_ready);
    end
    in_valid = '0;
  endtask

  task automatic test_backpressure;
    @(posedge clk);
    #1;
    sel        = 2'd1;
    in_valid   = 4'b0010;
    in_data[1] = 64'hA1A1_0001;
    out_ready  = 1'b1;
    @(posedge clk);
    #1;
    out_ready  = 1'b0;
    in_data[1] = 64'hA2A2_0002;
    repeat (3) begin
      @(negedge clk);
      #1;
      checks++;
      if (in_ready !== 4'b0 || out_data !== 64'hA1A1_0001
          || out_src !== 2'd1 || out_valid !== 1'b1) begin
        errors++;
        $display("FAIL bp_hold rdy %b data %h src %0d v %b",
                 in_ready, out_data, out_src, out_valid);
      end
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if (in_ready !== 4'b0010) begin
      errors++;
      $display("FAIL bp_release got %b want 0010", in_ready);
    end
    @(posedge clk);
    #1;
    checks++;
    if (out_data !== 64'hA2A2_0002 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL bp_reload got %h/%b want a2a20002/1",
               out_data, out_valid);
    end
    in_valid = '0;
  endtask

  task automatic test_reset_mid;
    @(posedge clk);
    #1;
    sel        = 2'd0;
    in_valid   = 4'b0001;
    in_data[0] = 64'h0123_4567_89AB_CDEF;
    out_ready  = 1'b0;
    @(posedge clk);
    #1;
    in_valid = '0;
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL rm_load got %b want 1", out_valid);
    end
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 64'h0) begin
      errors++;
      $display("FAIL rm_clear got %b/%h want 0/0",
               out_valid, out_data);
    end
    reset_n   = 1'b1;
    out_ready = 1'b1;
  endtask

  task automatic test_sel_oob;
    @(posedge clk);
    #1;
    sel3        = 2'd2;
    in_valid3   = 3'b100;
    in_data3[2] = 8'h5A;
    out_ready3  = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (out_valid3 !== 1'b1 || out_src3 !== 2'd2
        || out_data3 !== 8'h5A) begin
      errors++;
      $display("FAIL oob_load got %b/%0d/%h want 1/2/5a",
               out_valid3, out_src3, out_data3);
    end
    sel3 = 2'd3;
    @(negedge clk);
    #1;
    checks++;
    if (in_ready3 !== 3'b000) begin
      errors++;
      $display("FAIL oob_ready got %b want 000", in_ready3);
    end
    @(posedge clk);
    #1;
    checks++;
    if (out_valid3 !== 1'b0) begin
      errors++;
      $display("FAIL oob_drain got %b want 0", out_valid3);
    end
    in_valid3 = '0;
    sel3      = '0;
  endtask

`ifdef MUXN_ARB_RR_EN
  task automatic test_rr_fairness;
    logic [63:0] dv [4];
    for (int i = 0; i < 4; i++) begin
      dv[i] = 64'hC0DE_0000 + 64'(i);
    end
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    reset_n   = 1'b1;
    sel_mode  = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) in_data[i] = dv[i];
    in_valid = 4'hF;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #2;
      checks++;
      if (out_src !== 2'(i % 4) || out_data !== dv[i % 4]) begin
        errors++;
        $display("FAIL rr_fair[%0d] got %0d/%h want %0d/%h",
                 i, out_src, out_data, i % 4, dv[i % 4]);
      end
    end
    in_valid = '0;
    sel_mode = 1'b0;
  endtask

  task automatic test_rr_skip;
    logic [1:0] want [2];
    want[0] = 2'd3;
    want[1] = 2'd1;
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    reset_n   = 1'b1;
    sel_mode  = 1'b1;
    out_ready = 1'b1;
    in_valid  = 4'b0010;
    @(posedge clk);
    #1;
    in_valid = 4'b1010;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      #1;
      checks++;
      if (in_ready[0] !== 1'b0 || in_ready[2] !== 1'b0) begin
        errors++;
        $display("FAIL rr_skip_rdy got %b want x0x0", in_ready);
      end
      @(posedge clk);
      #2;
      checks++;
      if (out_src !== want[i]) begin
        errors++;
        $display("FAIL rr_skip[%0d] got %0d want %0d",
                 i, out_src, want[i]);
      end
    end
    in_valid = '0;
    sel_mode = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_passthrough();
    test_backpressure();
    test_reset_mid();
    test_sel_oob();
`ifdef MUXN_ARB_RR_EN
    test_rr_fairness();
    test_rr_skip();
`endif
    repeat (3) @(posedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/muxn_arb.md
# muxn_arb

Parametrised N-input, WIDTH-bit registered multiplexer with valid/ready handshaking on every input channel and on the output. It is the successor of the single-bit 2:1 gate-level mux. It selects one source per cycle, either from an explicit select or by a round-robin scan, and captures that source in a one-entry output register. It sits between datapath producers, such as register-file read ports and forwarding sources, and any consumer that can stall.

## Interface
Parameters:
- WIDTH, 64: data bits per channel.
- N, 4: number of input channels, minimum 2.
- SELW, $clog2(N): select and source-index width (derived).

Ports:
- clk  in  1  single clock, rising edge.
- reset_n  in  1  reset, synchronous, active-low.
- in_data  in  N×WIDTH  per-channel data.
- in_valid  in  N  per-channel valid.
- in_ready  out  N  per-channel ready. At most one bit is high in any cycle.
- sel  in  SELW  explicit channel select.
- sel_mode  in  1  0 = explicit select, 1 = round-robin.
- out_data  out  WIDTH  registered output data.
- out_valid  out  1  output register holds a word.
- out_ready  in  1  consumer accepts the word.
- out_src  out  SELW  index of the channel the held word came from.

## Operation
- Load enable: load = !out_valid || out_ready. The output register accepts a new word only when load = 1.
- Explicit mode (sel_mode = 0):
  - grant = sel.
  - in_ready[sel] = load; all other in_ready bits = 0.
  - If sel >= N (non-power-of-2 N), there is no grant and all in_ready = 0.
- Round-robin mode (sel_mode = 1):
  - grant = first channel c with in_valid[c] = 1, scanning cyclically from ptr+1 through ptr (wrap at N-1 → 0).
  - in_ready[grant] = load. If no channel is valid, all in_ready = 0.
  - ptr ← grant only on a transfer (in_valid[grant] && in_ready[grant]).
  - ptr keeps its value in explicit mode.
- Input transfer:
  - out_data ← in_data[grant], out_src ← grant, out_valid ← 1.
- Output transfer with no input transfer: out_valid ← 0. out_data and out_src keep their values.
- in_ready never depends combinationally on in_valid of the same channel in explicit mode. In round-robin mode it may.
- Mode switch mid-stream: the new mode governs selection in the same cycle. A held word is unaffected.

## Timing
- Reset (reset_n = 0 at an edge):
  - out_valid = 0, out_data = 0, out_src = 0.
  - ptr = N-1, so channel 0 has first priority.
  - in_ready is combinational; it is high for the selected channel after reset because out_valid = 0.
- Latency: 1 cycle from input transfer to out_valid/out_data.
- Throughput: 1 word/cycle while out_ready stays high. Simultaneous output transfer and input transfer in one cycle replaces the held word with no bubble.
- Backpressure: out_ready = 0 with out_valid = 1 holds out_data/out_src stable, and all in_ready = 0.
- Reset mid-operation discards the held word; no transfer completes in the reset cycle.
- Combinational paths:
  - out_ready → in_ready.
  - sel/sel_mode/in_valid → in_ready.
  - There is no path from inputs to out_*.

## Configuration
- MUXN_ARB_RR_EN:
  - Defined: round-robin mode, ptr register and arbiter are built.
  - Undefined: sel_mode is ignored and the block is explicit-select only. There is no ptr state.

## Structure
- Package muxn_pkg holds:
  - typedef enum logic {MODE_SEL, MODE_RR} mux_mode_e;
  - localparam DEFAULT_WIDTH = 64.
- Sub-module rr_arbiter (parameter N) holds the rotation-priority pick.
  - Inputs: req[N], ptr.
  - Outputs: gnt_idx, gnt_any.
  - Purely combinational; instantiated only under MUXN_ARB_RR_EN.
- The output register and handshake live in muxn_arb.

## Test plan
- Reset, explicit mode: reset_n = 0 for 2 cycles. Then out_valid = 0, out_data = 0, out_src = 0.
- Explicit pass-through: sel = 2, in_valid = 4'b0100, in_data[2] = 64'hDEAD_BEEF, out_ready = 1. The next cycle gives out_data = 64'hDEAD_BEEF, out_src = 2, out_valid = 1; in_ready = 4'b0100 throughout.
- Backpressure: out_valid = 1 with out_ready = 0 for 3 cycles. Required: in_ready = 0, out_data stable. Raising out_ready gives transfer plus reload in the same cycle.
- Round-robin fairness: sel_mode = 1, all in_valid = 1, out_ready = 1. Over 8 cycles out_src = 0,1,2,3,0,1,2,3.
- Round-robin skip: in_valid = 4'b1010 with ptr = 1. out_src = 3 then 1; channels 0 and 2 never get in_ready.
- Boundaries:
  - N = 3 with sel = 3 gives all in_ready = 0 and out_valid falls after drain.
  - reset_n low while out_valid = 1 clears out_valid on the next edge.
